uart_cmd_wrapper: RTL
=====================

# uart_cmd_wrapper

Knight-side endpoint of the remote command link. Deserializes two UART bytes from the remote into one 16-bit command (high byte first), presents it to the command processor with a ready/clear handshake, and serializes the 8-bit response byte back to the remote. It sits between the `RX`/`TX` pins and the command processor, pairing with the remote's command sender on the far end of the same 8N1 link.

## Interface

**Parameters**
- `BAUD_CLKS`, default 2604: clocks per bit (50 MHz / 19200). Must be ≥ 16.

**Ports**
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `RX`  in  1  serial in from remote, idle high, asynchronous to `clk`
- `TX`  out  1  serial out to remote, idle high
- `cmd`  out  16  assembled command, `{byte1, byte2}`
- `cmd_rdy`  out  1  `cmd` valid
- `clr_cmd_rdy`  in  1  consumer acknowledges `cmd`
- `resp`  in  8  response byte (0xA5 = positive ack)
- `trmt`  in  1  one-cycle pulse: send `resp`
- `tx_done`  out  1  response fully shifted out

## Operation

**RX path**
- `RX` passes through 2 flops, then a third for edge detect.
- A falling edge while idle starts reception. The start bit is resampled at `BAUD_CLKS/2`; if it reads 1, this is a glitch and the path returns to idle.
- 8 data bits, LSB first, each sampled at mid-bit (`BAUD_CLKS` apart). Then the stop bit.
- Stop bit = 0 is a framing error: the byte is discarded, no `rx_rdy`.
- `rx_rdy` is an internal one-cycle pulse with `rx_data`.

**Assembly FSM** (states `HIGH`, `LOW`; reset → `HIGH`)
- `HIGH` + `rx_rdy`: latch `rx_data` into `cmd[15:8]`, go to `LOW`.
- `LOW` + `rx_rdy`: latch `cmd[7:0]`, set `cmd_rdy`, go to `HIGH`.
- `cmd_rdy` clears on `clr_cmd_rdy`, or on acceptance of a new high byte.
- `clr_cmd_rdy` and a low-byte `rx_rdy` in the same cycle: set wins.
- `cmd` changes only on byte latches. `cmd[15:8]` is overwritten at the high byte of the next command, so the consumer must sample by then.
- No inter-byte timeout. A dropped byte misaligns pairing until reset.

**TX path**
- `trmt` while idle: load `{1'b1, resp, 1'b0}` into a 10-bit shifter, clear `tx_done`, start shifting. Each bit lasts `BAUD_CLKS`; LSB goes out first.
- `trmt` while busy is ignored.
- After the stop bit completes: set `tx_done` and hold it until the next accepted `trmt`.
- RX and TX operate fully concurrently.

## Timing

- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `tx_done`=0, FSM=`HIGH`, both shifters idle.
- `rx_rdy` fires at the mid-stop-bit sample, ~9.5·`BAUD_CLKS` + 3 (sync) after the start edge.
- `cmd_rdy` rises the clock after the low-byte `rx_rdy`.
- `TX` start bit drives low the clock after `trmt`.
- `tx_done` rises 10·`BAUD_CLKS` + 1 clocks after `trmt`.
- Reset mid-frame aborts immediately: `TX`=1, partial byte discarded.
- Baud counter width: `$clog2(BAUD_CLKS)`; it reloads on every bit boundary. The bit counter is 4 bits and counts to 10.

## Structure

- Shared package `uart_pkg`: `BAUD_CLKS_DEFAULT`, FSM enum `asm_state_t` {`HIGH`, `LOW`}, `RESP_ACK` = 8'hA5.
- Sub-module `uart_trx`: byte-level transceiver (`rx_rdy`/`rx_data`, `trmt`/`tx_data`/`tx_done`), parameterized by `BAUD_CLKS`. Contains no command awareness.
- `uart_cmd_wrapper` contains the assembly FSM, the `cmd` register and the `cmd_rdy` logic.

## Test plan

Use a bench-side serial model at `BAUD_CLKS`=16.

1. **Basic command:** send 0x43, 0xF3 → `cmd`=16'h43F3, `cmd_rdy`=1 one clock after the second stop sample. Pulse `clr_cmd_rdy` → `cmd_rdy`=0, `cmd` unchanged.
2. **Response:** `resp`=8'hA5 with a `trmt` pulse → `TX` shows 0,1,0,1,0,0,1,0,1,1 at 16-clock intervals. `tx_done`=1 at clock 161 and stays high. A second `trmt` issued mid-frame causes no disruption.
3. **Back-to-back:** commands 0x2900 then 0x5BF2 with no gap and no `clr_cmd_rdy` → `cmd_rdy` drops at the 0x5B latch. It rises again with `cmd`=16'h5BF2.
4. **Glitch / framing:** a 3-clock low pulse on `RX` → no byte. A byte 0x12 sent with stop=0 → no `rx_rdy`, FSM stays in `HIGH`. Following 0x06, 0x00 → `cmd`=16'h0600.
5. **Concurrency / set-wins:** receive a command while transmitting 0x5A → both complete correctly. Assert `clr_cmd_rdy` on the low-byte `rx_rdy` cycle → `cmd_rdy`=1.
6. **Reset mid-operation:** assert `rst_n`=0 mid-TX frame and after the first RX byte → `TX`=1, `cmd_rdy`=0, `cmd`=0 asynchronously. Next pair 0x20, 0x00 → `cmd`=16'h2000.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the remote command UART link.
package uart_pkg;

  localparam int BAUD_CLKS_DEFAULT = 2604;

  typedef enum logic {
    HIGH,
    LOW
  } asm_state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/uart_trx.sv
// 8N1 byte transceiver: rx_rdy ~9.5 bit times + 3 clks after start edge, TX starts 1 clk after trmt.
// No backpressure: rx_rdy is a one-cycle pulse, trmt while busy is dropped.
module uart_trx
  import uart_pkg::*;
#(
  parameter int BAUD_CLKS = BAUD_CLKS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_CLKS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CLKS - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_CLKS / 2 - 1);

  logic          rx_ff1, rx_ff2, rx_ff3;
  logic          rx_busy;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_shift;

  logic          tx_busy;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_ff2   <= 1'b1;
      rx_ff3   <= 1'b1;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_ff1 <= rx;
      rx_ff2 <= rx_ff1;
      rx_ff3 <= rx_ff2;
      rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (rx_ff3 && !rx_ff2) begin
          rx_busy <= 1'b1;
          rx_baud <= BAUD_HALF;
          rx_bits <= '0;
        end
      end else if (rx_baud != '0) begin
        rx_baud <= rx_baud - 1'b1;
      end else begin
        rx_baud <= BAUD_LAST;
        rx_bits <= rx_bits + 4'd1;
        // bit 0 is the start-bit recheck, bit 9 the stop bit
        if (rx_bits == 4'd0) begin
          if (rx_ff2) rx_busy <= 1'b0;
        end else if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_ff2) begin
            rx_rdy  <= 1'b1;
            rx_data <= rx_shift;
          end
        end else begin
          rx_shift <= {rx_ff2, rx_shift[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else if (!tx_busy) begin
      if (trmt) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_busy  <= 1'b1;
        tx_done  <= 1'b0;
        tx_baud  <= BAUD_LAST;
        tx_bits  <= '0;
      end
    end else if (tx_baud != '0) begin
      tx_baud <= tx_baud - 1'b1;
    end else begin
      tx_baud  <= BAUD_LAST;
      tx_shift <= {1'b1, tx_shift[9:1]};
      tx_bits  <= tx_bits + 4'd1;
      if (tx_bits == 4'd9) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end
    end
  end

  // Shifter fills with ones, so the line idles high without a separate mux.
  assign tx = tx_shift[0];

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Pairs received bytes into 16-bit commands (cmd_rdy 1 clk after low byte) and sends response bytes.
// No backpressure on RX: an unconsumed cmd is overwritten; trmt while transmitting is dropped.
module uart_cmd_wrapper
  import uart_pkg::*;
#(
  parameter int BAUD_CLKS = BAUD_CLKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  logic       rx_rdy;
  logic [7:0] rx_data;
  asm_state_t state;

  uart_trx #(
    .BAUD_CLKS(BAUD_CLKS)
  ) u_trx (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (RX),
    .tx     (TX),
    .rx_rdy (rx_rdy),
    .rx_data(rx_data),
    .trmt   (trmt),
    .tx_data(resp),
    .tx_done(tx_done)
  );

  // A new byte takes priority over clr_cmd_rdy, so a coincident low byte still raises cmd_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HIGH;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else if (rx_rdy) begin
      case (state)
        HIGH: begin
          cmd[15:8] <= rx_data;
          cmd_rdy   <= 1'b0;
          state     <= LOW;
        end
        LOW: begin
          cmd[7:0] <= rx_data;
          cmd_rdy  <= 1'b1;
          state    <= HIGH;
        end
        default: state <= HIGH;
      endcase
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

endmodule
